// File: rtl/img_pkg.sv
// Shared types and elaboration helpers for the windowed image
// sequencer: state encoding, derived widths, parameter legality.
package img_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RUN  = 2'd2,
    WR   = 2'd3
  } state_t;

  function automatic int unsigned wid(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ncol_of(
    input int unsigned col_max,
    input int unsigned ppw
  );
    return (ppw == 0) ? 0 : col_max / ppw;
  endfunction

  function automatic int unsigned cw_of(
    input int unsigned col_max,
    input int unsigned ppw,
    input int unsigned lat
  );
    return wid(ncol_of(col_max, ppw) + lat);
  endfunction

  function automatic int unsigned rw_of(input int unsigned row_max);
    return wid(row_max);
  endfunction

  function automatic bit params_ok(
    input int unsigned col_max,
    input int unsigned row_max,
    input int unsigned ppw,
    input int unsigned win,
    input int unsigned lat
  );
    if (ppw == 0) return 1'b0;
    if ((col_max % ppw) != 0) return 1'b0;
    if (ncol_of(col_max, ppw) == 0) return 1'b0;
    if (win < 1 || win > 8) return 1'b0;
    if (row_max < win) return 1'b0;
    if (lat >= ncol_of(col_max, ppw)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/img_win_ctl_scan_cnt.sv
// Nested row / column-group / read-index / pixel-phase counters,
// stepped by advance strobes with wrap flags back to the FSM.
module img_scan_cnt
  import img_pkg::*;
#(
  parameter int unsigned NROW = 2,
  parameter int unsigned NCT  = 3,
  parameter int unsigned WIN  = 3,
  parameter int unsigned PPW  = 4,
  parameter int unsigned RW   = 2,
  parameter int unsigned CW   = 2,
  parameter int unsigned KW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          k_adv,
  input  logic          p_adv,
  input  logic          c_adv,
  input  logic          r_adv,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic [KW-1:0] k,
  output logic          k_last,
  output logic          p_last,
  output logic          c_last,
  output logic          r_last
);

  localparam int unsigned PW = wid(PPW);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;

  assign k_last = (k_q == KW'(WIN - 1));
  assign p_last = (p_q == PW'(PPW - 1));
  assign c_last = (c_q == CW'(NCT - 1));
  assign r_last = (r_q == RW'(NROW - 1));

  assign r = r_q;
  assign c = c_q;
  assign k = k_q;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    p_d = p_q;
    if (clr) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
      p_d = '0;
    end else begin
      if (k_adv) k_d = k_last ? '0 : k_q + KW'(1);
      if (p_adv) p_d = p_last ? '0 : p_q + PW'(1);
      if (c_adv) c_d = c_last ? '0 : c_q + CW'(1);
      if (r_adv) r_d = r_last ? '0 : r_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      p_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/img_win_ctl.sv
// Column-group frame sequencer: window reads, pipeline run,
// result write, end-of-row drain, abort and bus timeout.
module img_win_ctl
  import img_pkg::*;
#(
  parameter  int unsigned COL_MAX      = 600,
  parameter  int unsigned ROW_MAX      = 400,
  parameter  int unsigned PIX_PER_WORD = 4,
  parameter  int unsigned WIN_ROWS     = 3,
  parameter  int unsigned PIPE_LAT     = 1,
  parameter  int unsigned TO_CYC       = 255,
  localparam int unsigned CW = cw_of(COL_MAX, PIX_PER_WORD, PIPE_LAT),
  localparam int unsigned RW = rw_of(ROW_MAX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                bus_cs_n,
  output logic                bus_we_o,
  input  logic                bus_ack_i,
  output logic [RW-1:0]       src_row,
  output logic [CW-1:0]       src_col,
  output logic [RW-1:0]       dst_row,
  output logic [CW-1:0]       dst_col,
  output logic [WIN_ROWS-1:0] load,
  output logic                en_pipe,
  output logic                flush,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned NCOL = ncol_of(COL_MAX, PIX_PER_WORD);
  localparam int unsigned NROW = ROW_MAX - WIN_ROWS + 1;
  localparam int unsigned KW   = wid(WIN_ROWS);
  localparam int unsigned TW   = wid(TO_CYC + 1);

  localparam logic [CW:0]   NCOL_X  = (CW+1)'(NCOL);
  localparam logic [CW:0]   NCOL_M1 = (CW+1)'(NCOL - 1);
  localparam logic [CW:0]   LAT_X   = (CW+1)'(PIPE_LAT);
  localparam logic [TW-1:0] T_END   = TW'(TO_CYC - 1);
  localparam bit            TO_EN   = (TO_CYC != 0);

  if (!params_ok(COL_MAX, ROW_MAX, PIX_PER_WORD, WIN_ROWS, PIPE_LAT))
  begin : g_bad_cfg
    $error("img_win_ctl: illegal parameter set");
  end

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          clr, k_adv, p_adv, c_adv, r_adv;
  logic          k_last, p_last, c_last, r_last;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [KW-1:0] k;
  logic [CW:0]   c_x;
  logic          in_rd, in_wr, to_hit;

  img_scan_cnt #(
    .NROW (NROW),
    .NCT  (NCOL + PIPE_LAT),
    .WIN  (WIN_ROWS),
    .PPW  (PIX_PER_WORD),
    .RW   (RW),
    .CW   (CW),
    .KW   (KW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .k_adv  (k_adv),
    .p_adv  (p_adv),
    .c_adv  (c_adv),
    .r_adv  (r_adv),
    .r      (r),
    .c      (c),
    .k      (k),
    .k_last (k_last),
    .p_last (p_last),
    .c_last (c_last),
    .r_last (r_last)
  );

  assign in_rd  = (state_q == RD);
  assign in_wr  = (state_q == WR);
  assign c_x    = {1'b0, c};
  assign to_hit = TO_EN && (t_q == T_END);

  always_comb begin
    state_d = state_q;
    t_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    k_adv   = 1'b0;
    p_adv   = 1'b0;
    c_adv   = 1'b0;
    r_adv   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RD;
      RD: if (bus_ack_i) begin
        k_adv = 1'b1;
        if (k_last) state_d = RUN;
      end
      RUN: begin
        p_adv = 1'b1;
        if (p_last) begin
          if (c_x >= LAT_X) begin
            state_d = WR;
          end else begin
            c_adv   = 1'b1;
            state_d = RD;
          end
        end
      end
      WR: if (bus_ack_i) begin
        c_adv = 1'b1;
        if (!c_last) begin
          // groups past the last source column only drain the pipe
          state_d = (c_x < NCOL_M1) ? RD : RUN;
        end else if (r_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          clr     = 1'b1;
        end else begin
          r_adv   = 1'b1;
          state_d = RD;
        end
      end
      default: ;
    endcase
    if ((in_rd || in_wr) && !bus_ack_i) begin
      if (to_hit) begin
        state_d = IDLE;
        err_d   = 1'b1;
        clr     = 1'b1;
      end else begin
        t_d = t_q + TW'(1);
      end
    end
    if (abort) begin
      state_d = IDLE;
      clr     = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      t_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_cs_n = !(in_rd || in_wr);
  assign bus_we_o = in_wr;
  assign busy     = (state_q != IDLE);
  assign en_pipe  = (state_q == RUN);
  assign flush    = en_pipe && (c_x >= NCOL_X);
  assign done     = done_q;
  assign err      = err_q;

  assign src_row = in_rd ? r + RW'(k) : '0;
  assign src_col = in_rd ? c : '0;
  assign dst_row = in_wr ? r : '0;
  assign dst_col = in_wr ? c - CW'(PIPE_LAT) : '0;
  assign load    = (in_rd && bus_ack_i) ? (WIN_ROWS'(1) << k) : '0;

endmodule

// File: doc/img_win_ctl.md
Name: img_win_ctl

Overview:
Parametrised successor to the single-size image-processing sequencer. It scans a frame in column groups of PIX_PER_WORD pixels. For each group it reads a WIN_ROWS-tall stack of words over the system bus, then runs the pixel pipeline for PIX_PER_WORD cycles and writes one result word once the pipeline is primed. It sits between the system-bus master port and the window datapath. Over its predecessor it adds:
- configurable window height and pipeline latency;
- explicit source and destination coordinates;
- an end-of-row drain phase;
- abort, bus-timeout error, and busy/done status.

Parameters:
COL_MAX, 600, pixels per image row; must be a multiple of PIX_PER_WORD.
ROW_MAX, 400, rows per frame; must be ≥ WIN_ROWS.
PIX_PER_WORD, 4, pixels per bus word, which is also the en_pipe cycles per column group.
WIN_ROWS, 3, bus reads (source rows) per column group; range 1..8.
PIPE_LAT, 1, column groups before the first valid result; range 0..NCOL-1.
TO_CYC, 255, maximum wait for bus_ack_i in cycles; 0 disables the timeout.
Derived: NCOL = COL_MAX/PIX_PER_WORD; NROW = ROW_MAX-WIN_ROWS+1; CW = clog2(NCOL+PIPE_LAT); RW = clog2(ROW_MAX).

Ports:
clk  in  1  processing clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; sampled only in IDLE
abort  in  1  level; forces return to IDLE
bus_cs_n  out  1  bus select, active-low
bus_we_o  out  1  1 = write transaction
bus_ack_i  in  1  slave acknowledge; completes the current transaction
src_row  out  RW  source row of the current read (r+k)
src_col  out  CW  source column group of the current read
dst_row  out  RW  destination row of the current write
dst_col  out  CW  destination column group of the current write
load  out  WIN_ROWS  one-hot; bit k = bus read data belongs to window row k
en_pipe  out  1  pipeline advance
flush  out  1  en_pipe cycle carrying no new input (drain)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: frame complete
err  out  1  one-cycle pulse: bus timeout

Behaviour:
- All outputs are 0 at reset, except bus_cs_n = 1. State resets to IDLE; all counters reset to 0.
- Counters:
  - r: row position, 0..NROW-1.
  - c: column group, 0..NCOL+PIPE_LAT-1.
  - k: read index, 0..WIN_ROWS-1.
  - p: pixel phase, 0..PIX_PER_WORD-1.
  - t: timeout count.
- States and transitions:
  - IDLE: if start and not abort, go to RD with r=c=k=0.
  - RD: on ack with k < WIN_ROWS-1, increment k. On ack with k = WIN_ROWS-1, clear k and go to RUN.
  - RUN: increment p each cycle. When p = PIX_PER_WORD-1, clear p; go to WR if c ≥ PIPE_LAT, else increment c and go to RD.
  - WR: on ack, if c < NCOL+PIPE_LAT-1, increment c. The next state is RD if the new c < NCOL, else RUN (drain).
  - WR, end of row: on ack with c = NCOL+PIPE_LAT-1, clear c. If r = NROW-1, go to IDLE and pulse done; otherwise increment r and go to RD.
- Drain: RUN with c ≥ NCOL asserts en_pipe and flush together; no reads occur.
- PIPE_LAT = 0 edge case: the first group writes immediately and no drain occurs.
- Bus signals:
  - bus_cs_n = 0 exactly while state ∈ {RD, WR}.
  - bus_we_o = 1 exactly while state = WR.
  - Both are decoded from the state register; there is no combinational path from bus_ack_i to bus outputs.
  - bus_ack_i is ignored outside RD/WR.
  - The minimum transaction length is 1 cycle (ack in the same cycle cs_n is first low).
- Coordinate outputs: in RD, src_row = r+k and src_col = c. In WR, dst_row = r and dst_col = c-PIPE_LAT.
- load[k] = bus_ack_i & (state == RD) & (k index): combinational, coincident with the data.
- en_pipe = (state == RUN). flush = en_pipe & (c ≥ NCOL).
- Timeout:
  - t increments while in RD/WR without ack and clears on ack or on state change.
  - When t = TO_CYC-1 without ack: go to IDLE, pulse err, do not pulse done. Counters clear.
- abort: in any state, the next state is IDLE and counters clear. A pending transaction is dropped; bus_cs_n returns to 1 the next cycle. done and err are not pulsed. If abort and ack coincide, abort wins.
- start held high in IDLE after done: a new frame starts on the next cycle. start is ignored while busy.
- Reset mid-transaction: bus_cs_n goes to 1 immediately (asynchronously).
- Frame totals:
  - reads = NROW·NCOL·WIN_ROWS
  - writes = NROW·NCOL
  - en_pipe cycles = NROW·(NCOL+PIPE_LAT)·PIX_PER_WORD

Decomposition:
- Package img_pkg holds:
  - the state enum (IDLE, RD, RUN, WR);
  - derived-width functions (clog2-based NCOL/CW/RW);
  - the parameter legality checks (elaboration-time assertions).
- One sub-module, img_scan_cnt: the nested r/c/k/p counters with wrap flags, driven by advance strobes from the FSM. The FSM, bus decode and timeout stay in img_win_ctl.

Test Plan:
- COL_MAX=8, PIX_PER_WORD=4, ROW_MAX=4, WIN_ROWS=3, PIPE_LAT=1, ack tied 1, start pulse → exactly 12 reads, 4 writes, 24 en_pipe cycles, 8 of them with flush. dst_col sequence 0,1,0,1; dst_row 0,0,1,1; done pulses once; busy then falls.
- Same config with ack delayed 3 cycles per transaction → bus_cs_n held low 4 cycles per transaction. Each load bit pulses only on the ack cycle; src_row cycles r, r+1, r+2. Totals are unchanged.
- TO_CYC=5, ack never asserted on the 2nd read → err pulses after 5 cycles in RD, state returns to IDLE, done is never asserted, bus_cs_n = 1.
- abort asserted on the same cycle as a WR ack mid-frame → next cycle IDLE, no done, no counter advance. A following start restarts from r=0, c=0 (src_row=0).
- PIPE_LAT=0, WIN_ROWS=1, COL_MAX=8, ROW_MAX=2 → each group does RD, RUN, WR with no flush; 4 reads, 4 writes.
- Async reset asserted while bus_cs_n = 0 → bus_cs_n = 1 and busy = 0 before the next clk edge; all pulses stay 0.
